core_issue_window: RTL

Parametrised in-order issue window for the real-TOY core. It sits between fetch and the execute/LSU back end and buffers up to DEPTH fetched instructions. Each cycle it issues the longest hazard-free prefix of up to ISSUE_W instructions, using a 16-entry register scoreboard. It generalises the single-slot cascade decode to a configurable width, and adds real buffering, a writeback-driven scoreboard, flush and a sticky halt.

---
 rtl/core_issue_window_if.sv | 74 +++++++
 rtl/core_issue_window.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_issue_window_if.sv
// ---------------------------------------------------------------------------
// core_issue_window_if
//
// Purpose : bundles every non-clock, non-reset signal of the issue window:
//           the fetch handshake, the issued group towards the back end, the
//           register writeback port, the redirect flush and the halt status.
//
// Parameter
//   ISSUE_W        maximum instructions issued per cycle (slot count).
//
// Signals (direction as seen by the issue window, i.e. the slave modport)
//   fetch_valid_i   in   1          fetch offers an instruction
//   fetch_instr_i   in   16         TOY instruction word
//   fetch_pc_i      in   8          PC of the offered instruction
//   fetch_ready_o   out  1          window takes the offered instruction
//   issue_valid_o   out  ISSUE_W    thermometer mask of issued slots
//   issue_instr_o   out  16*ISSUE_W instruction per slot (slot 0 = oldest)
//   issue_pc_o      out  8*ISSUE_W  PC per slot
//   issue_ready_i   in   1          back end accepts the whole group
//   wb_en_i         in   1          a register write completed
//   wb_rd_i         in   4          register that was written
//   flush_i         in   1          redirect, discard window contents
//   halted_o        out  1          a halt has issued (sticky)
//
// Modports
//   slave  : the issue window itself
//   master : the surrounding core / testbench driving fetch and back end
// ---------------------------------------------------------------------------
interface core_issue_window_if #(
  parameter int ISSUE_W = 2
);
  logic                   fetch_valid_i;
  logic [15:0]            fetch_instr_i;
  logic [7:0]             fetch_pc_i;
  logic                   fetch_ready_o;
  logic [ISSUE_W-1:0]     issue_valid_o;
  logic [16*ISSUE_W-1:0]  issue_instr_o;
  logic [8*ISSUE_W-1:0]   issue_pc_o;
  logic                   issue_ready_i;
  logic                   wb_en_i;
  logic [3:0]             wb_rd_i;
  logic                   flush_i;
  logic                   halted_o;

  modport slave (
    input  fetch_valid_i,
    input  fetch_instr_i,
    input  fetch_pc_i,
    output fetch_ready_o,
    output issue_valid_o,
    output issue_instr_o,
    output issue_pc_o,
    input  issue_ready_i,
    input  wb_en_i,
    input  wb_rd_i,
    input  flush_i,
    output halted_o
  );

  modport master (
    output fetch_valid_i,
    output fetch_instr_i,
    output fetch_pc_i,
    input  fetch_ready_o,
    input  issue_valid_o,
    input  issue_instr_o,
    input  issue_pc_o,
    output issue_ready_i,
    output wb_en_i,
    output wb_rd_i,
    output flush_i,
    input  halted_o
  );
endinterface

// File: rtl/core_issue_window.sv
// ---------------------------------------------------------------------------
// core_issue_window
//
// Purpose : in-order issue window for the real-TOY core. Buffers up to DEPTH
//           fetched instructions in a circular FIFO and each cycle offers the
//           longest hazard-free prefix of up to ISSUE_W of them to the back
//           end. Hazards are tracked by a 16-entry dirty-bit scoreboard that is
//           set on issue and cleared by writeback. Supports flush (redirect)
//           and a sticky halt.
//
// Parameters
//   DEPTH    window entries (>= ISSUE_W, >= 2; need not be a power of two)
//   ISSUE_W  maximum instructions issued per cycle (>= 1)
//
// Ports
//   clk_i    clock, all state updates on the rising edge
//   rst_i    synchronous active-high reset
//   bus      core_issue_window_if.slave: fetch, issue, writeback, flush, halt
//
// Build option
//   CORE_ISSUE_WB_BYPASS_EN : when defined, a writeback clears its dirty bit
//   for the same-cycle eligibility check, so a dependant issues in the
//   writeback cycle. When undefined the clear only takes effect at the edge.
// ---------------------------------------------------------------------------
module core_issue_window #(
  parameter int DEPTH   = 4,
  parameter int ISSUE_W = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  core_issue_window_if.slave bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Register usage and class of one TOY opcode.
  typedef struct packed {
    logic src_rd;
    logic src_rs;
    logic src_rt;
    logic dst_rd;
    logic mem;
    logic ctrl;
    logic halt;
  } dec_t;

  function automatic dec_t decode_op(input logic [3:0] op);
    dec_t d;
    d = '0;
    case (op)
      4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6: begin
        d.src_rs = 1'b1;
        d.src_rt = 1'b1;
        d.dst_rd = 1'b1;
      end
      4'h7: d.dst_rd = 1'b1;
      4'h8: begin
        d.dst_rd = 1'b1;
        d.mem    = 1'b1;
      end
      4'h9: begin
        d.src_rd = 1'b1;
        d.mem    = 1'b1;
      end
      4'hA: begin
        d.src_rt = 1'b1;
        d.dst_rd = 1'b1;
        d.mem    = 1'b1;
      end
      4'hB: begin
        d.src_rd = 1'b1;
        d.src_rt = 1'b1;
        d.mem    = 1'b1;
      end
      4'hC, 4'hD, 4'hE: begin
        d.src_rd = 1'b1;
        d.ctrl   = 1'b1;
      end
      4'hF: begin
        d.dst_rd = 1'b1;
        d.ctrl   = 1'b1;
      end
      4'h0: d.halt = 1'b1;
      default: d = '0;
    endcase
    return d;
  endfunction

  function automatic logic [15:0] reg_bit(input logic [3:0] r);
    return 16'h0001 << r;
  endfunction

  // Pointer advance modulo DEPTH; n never exceeds DEPTH, so one wrap suffices.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                               input int unsigned    n);
    int unsigned s;
    s = 32'(p) + n;
    s = (s >= 32'(DEPTH)) ? (s - 32'(DEPTH)) : s;
    return s[PTR_W-1:0];
  endfunction

  // Architectural state
  logic [15:0]      instr_q [DEPTH];
  logic [7:0]       pc_q    [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [15:0]      dirty_q, dirty_d;
  logic             halted_q, halted_d;

  // Combinational helpers
  logic [15:0]            eff_dirty_s;
  logic [ISSUE_W-1:0]     valid_s;
  logic [16*ISSUE_W-1:0]  instr_bus_s;
  logic [8*ISSUE_W-1:0]   pc_bus_s;
  logic [15:0]            set_mask_s;
  logic                   halt_sel_s;
  logic [CNT_W-1:0]       pop_s;
  logic                   fetch_ready_s;
  logic                   push_s;
  logic                   xfer_s;

  assign fetch_ready_s = (count_q < CNT_W'(DEPTH)) && !halted_q && !bus.flush_i;
  assign push_s        = bus.fetch_valid_i && fetch_ready_s;
  assign xfer_s        = bus.issue_ready_i && (|valid_s) && !bus.flush_i;

  assign bus.fetch_ready_o = fetch_ready_s;
  assign bus.issue_valid_o = valid_s;
  assign bus.issue_instr_o = instr_bus_s;
  assign bus.issue_pc_o    = pc_bus_s;
  assign bus.halted_o      = halted_q;

  // Scoreboard view used for eligibility (optionally sees this cycle's writeback).
  always_comb begin
`ifdef CORE_ISSUE_WB_BYPASS_EN
    if (bus.wb_en_i) begin
      eff_dirty_s = dirty_q & ~reg_bit(bus.wb_rd_i);
    end else begin
      eff_dirty_s = dirty_q;
    end
`else
    eff_dirty_s = dirty_q;
`endif
  end

  // Walk the oldest ISSUE_W entries and build the eligible prefix.
  always_comb begin
    logic [15:0]      prior_dst;
    logic             chain;
    logic             ok;
    logic [PTR_W-1:0] idx;
    logic [15:0]      ins;
    dec_t             d;
    logic [15:0]      src_m;
    logic [15:0]      dst_m;
    logic [15:0]      touch_m;

    valid_s     = '0;
    instr_bus_s = '0;
    pc_bus_s    = '0;
    set_mask_s  = 16'h0000;
    halt_sel_s  = 1'b0;
    pop_s       = '0;
    prior_dst   = 16'h0000;
    chain       = !halted_q;
    ok          = 1'b0;
    idx         = '0;
    ins         = 16'h0000;
    d           = '0;
    src_m       = 16'h0000;
    dst_m       = 16'h0000;
    touch_m     = 16'h0000;

    for (int k = 0; k < ISSUE_W; k++) begin
      idx   = ptr_add(head_q, unsigned'(k));
      ins   = instr_q[idx];
      d     = decode_op(ins[15:12]);
      src_m = (d.src_rd ? reg_bit(ins[11:8]) : 16'h0000) |
              (d.src_rs ? reg_bit(ins[7:4])  : 16'h0000) |
              (d.src_rt ? reg_bit(ins[3:0])  : 16'h0000);
      dst_m = d.dst_rd ? reg_bit(ins[11:8]) : 16'h0000;
      touch_m = src_m | dst_m;

      // chain already folds in "previous slot eligible" and "no earlier
      // memory/control/halt op" -- any of those ends the group.
      ok = chain && (k < int'(count_q));
      if (d.halt) begin
        ok = ok && (k == 0) && (eff_dirty_s == 16'h0000) && bus.issue_ready_i;
      end else begin
        ok = ok && ((touch_m & eff_dirty_s) == 16'h0000)
                && ((touch_m & prior_dst)  == 16'h0000);
      end

      valid_s[k]              = ok;
      instr_bus_s[k*16 +: 16] = ins;
      pc_bus_s[k*8 +: 8]      = pc_q[idx];
      set_mask_s = set_mask_s | (ok ? (dst_m & 16'hFFFE) : 16'h0000);
      halt_sel_s = halt_sel_s | (ok && d.halt);
      pop_s      = ok ? CNT_W'(k + 1) : pop_s;
      prior_dst  = prior_dst | (dst_m & 16'hFFFE);
      chain      = ok && !(d.mem || d.ctrl || d.halt);
    end
  end

  // Next-state for pointers, occupancy, scoreboard and halt.
  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    halted_d = halted_q;
    // Writeback clears first so that a same-cycle issue set wins.
    if (bus.wb_en_i) begin
      dirty_d = dirty_q & ~reg_bit(bus.wb_rd_i);
    end else begin
      dirty_d = dirty_q;
    end

    if (bus.flush_i) begin
      // Scoreboard is kept: writes already in flight still complete.
      head_d  = tail_q;
      count_d = '0;
    end else begin
      if (xfer_s) begin
        head_d   = ptr_add(head_q, 32'(pop_s));
        dirty_d  = dirty_d | set_mask_s;
        halted_d = halted_q | halt_sel_s;
      end else begin
        head_d   = head_q;
      end
      if (push_s) begin
        tail_d = ptr_add(tail_q, 32'd1);
      end else begin
        tail_d = tail_q;
      end
      count_d = count_q + CNT_W'(push_s) - (xfer_s ? pop_s : {CNT_W{1'b0}});
    end
  end

  // State registers with synchronous reset; storage written on enqueue.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      dirty_q  <= 16'h0000;
      halted_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= 16'h0000;
        pc_q[i]    <= 8'h00;
      end
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      dirty_q  <= dirty_d;
      halted_q <= halted_d;
      if (push_s) begin
        instr_q[tail_q] <= bus.fetch_instr_i;
        pc_q[tail_q]    <= bus.fetch_pc_i;
      end else begin
        instr_q[tail_q] <= instr_q[tail_q];
        pc_q[tail_q]    <= pc_q[tail_q];
      end
    end
  end

endmodule
